// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Drives a byte-level command engine and reports ready, capacity class or an error code.
module sd_init_sequencer #(
    parameter int DUMMY_CYCLES   = 80,
    parameter int R1_TIMEOUT     = 16,
    parameter int ACMD41_RETRIES = 1000,
    parameter int GAP_BYTES      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_start,
    output logic [47:0] sd_cmd,
    output logic        sd_start,
    input  logic        sd_resp_toggle,
    input  logic [7:0]  sd_resp,
    output logic        busy,
    output logic        ready,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        sdhc,
    output logic [3:0]  dbg_state
);
    // Engine handshake: sd_start is a one-cycle launch with sd_cmd already stable the cycle
    // before; the engine reports each byte by flipping sd_resp_toggle, sd_resp valid that cycle.
    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY, S_ISSUE, S_SKIP, S_WAIT_R1, S_TAIL, S_GAP, S_READY, S_ERROR
    } state_t;
    typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_t;

    state_t      state_q;
    cmd_t        cmd_q;
    logic [15:0] cnt_q;
    logic [15:0] retry_q;
    logic        toggle_q;
    logic [7:0]  r1_q;
    logic        ccs_q;
    logic [3:0]  lo_q;
    logic [47:0] sd_cmd_q;
    logic        sd_start_q, busy_q, ready_q, error_q, sdhc_q;
    logic [2:0]  err_code_q;

    logic        byte_evt, has_tail, resp_done;
    logic [7:0]  chk_r1;
    logic        chk_ok, chk_last, chk_retry;
    cmd_t        chk_next;
    logic [2:0]  chk_code;

    function automatic logic [47:0] frame(input cmd_t c);
        case (c)
            C_CMD8:   frame = 48'h48000001AA87;
            C_CMD55:  frame = 48'h770000000001;
            C_ACMD41: frame = 48'h694000000001;
            C_CMD58:  frame = 48'h7A0000000001;
            default:  frame = 48'h400000000095;
        endcase
    endfunction

    assign byte_evt  = (sd_resp_toggle != toggle_q);
    assign has_tail  = (cmd_q == C_CMD8) || (cmd_q == C_CMD58);
    assign resp_done = byte_evt &&
                       (((state_q == S_WAIT_R1) && !sd_resp[7] && !has_tail) ||
                        ((state_q == S_TAIL) && (cnt_q == 16'd3)));

    // Response check runs on the final byte so ready/error land one cycle after it.
    always_comb begin
        chk_r1    = (state_q == S_WAIT_R1) ? sd_resp : r1_q;
        chk_ok    = 1'b0;
        chk_last  = 1'b0;
        chk_retry = 1'b0;
        chk_next  = C_CMD0;
        chk_code  = 3'd1;
        case (cmd_q)
            C_CMD0: begin
                chk_ok   = (chk_r1 == 8'h01);
                chk_next = C_CMD8;
                chk_code = 3'd1;
            end
            C_CMD8: begin
                chk_ok   = (chk_r1 == 8'h01) && ({lo_q, sd_resp} == 12'h1AA);
                chk_next = C_CMD55;
                chk_code = 3'd2;
            end
            C_CMD55: begin
                chk_ok   = (chk_r1 == 8'h00) || (chk_r1 == 8'h01);
                chk_next = C_ACMD41;
                chk_code = 3'd5;
            end
            C_ACMD41: begin
                chk_code = 3'd3;
                if (chk_r1 == 8'h00) begin
                    chk_ok   = 1'b1;
                    chk_next = C_CMD58;
                end else if ((chk_r1 == 8'h01) && (int'(retry_q) + 1 < ACMD41_RETRIES)) begin
                    chk_ok    = 1'b1;
                    chk_retry = 1'b1;
                    chk_next  = C_CMD55;
                end
            end
            C_CMD58: begin
                chk_ok   = (chk_r1 == 8'h00);
                chk_last = 1'b1;
                chk_code = 3'd4;
            end
            default: chk_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= C_CMD0;
            cnt_q      <= '0;
            retry_q    <= '0;
            toggle_q   <= sd_resp_toggle;
            r1_q       <= '0;
            ccs_q      <= 1'b0;
            lo_q       <= '0;
            sd_cmd_q   <= '0;
            sd_start_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            sdhc_q     <= 1'b0;
        end else begin
            toggle_q   <= sd_resp_toggle;
            sd_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_READY, S_ERROR: begin
                    if (init_start) begin
                        state_q    <= S_DUMMY;
                        cmd_q      <= C_CMD0;
                        cnt_q      <= '0;
                        retry_q    <= '0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= '0;
                        sdhc_q     <= 1'b0;
                    end
                end
                S_DUMMY: begin
                    if (cnt_q == 16'(DUMMY_CYCLES - 2)) begin
                        state_q  <= S_ISSUE;
                        sd_cmd_q <= frame(cmd_q);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_ISSUE: begin
                    sd_start_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= S_SKIP;
                end
                S_SKIP: begin
                    if (byte_evt && !sd_start_q) begin
                        if (cnt_q == 16'd5) begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT_R1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                S_WAIT_R1: begin
                    if (byte_evt) begin
                        if (!sd_resp[7]) begin
                            r1_q  <= sd_resp;
                            cnt_q <= '0;
                            if (has_tail) state_q <= S_TAIL;
                        end else if (cnt_q == 16'(R1_TIMEOUT - 1)) begin
                            state_q    <= S_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= chk_code;
                            busy_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (byte_evt) begin
                        if (cnt_q == 16'd0) ccs_q <= sd_resp[6];
                        if (cnt_q == 16'd2) lo_q <= sd_resp[3:0];
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_GAP: begin
                    if ((GAP_BYTES == 0) || (byte_evt && (cnt_q == 16'(GAP_BYTES - 1)))) begin
                        state_q  <= S_ISSUE;
                        sd_cmd_q <= frame(cmd_q);
                    end else if (byte_evt) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (resp_done) begin
                if (!chk_ok) begin
                    state_q    <= S_ERROR;
                    error_q    <= 1'b1;
                    err_code_q <= chk_code;
                    busy_q     <= 1'b0;
                end else if (chk_last) begin
                    state_q <= S_READY;
                    ready_q <= 1'b1;
                    sdhc_q  <= ccs_q;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= S_GAP;
                    cnt_q   <= '0;
                    cmd_q   <= chk_next;
                    if (chk_retry) retry_q <= retry_q + 16'd1;
                end
            end
        end
    end

    assign sd_cmd    = sd_cmd_q;
    assign sd_start  = sd_start_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign sdhc      = sdhc_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: a randomized SD card/engine model, a rule-level reference of the
// expected command sequence and outcome, and a monitor that checks every launch against it.
module tb_sd_init_sequencer;
    localparam int DUMMY   = 80;
    localparam int R1_TO   = 16;
    localparam int RETRIES = 3;
    localparam int GAPB    = 1;

    localparam logic [47:0] F_CMD0   = 48'h400000000095;
    localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55  = 48'h770000000001;
    localparam logic [47:0] F_ACMD41 = 48'h694000000001;
    localparam logic [47:0] F_CMD58  = 48'h7A0000000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_start = 1'b0;
    logic        sd_resp_toggle = 1'b0;
    logic [7:0]  sd_resp = 8'hFF;
    logic [47:0] sd_cmd;
    logic        sd_start, busy, ready, error, sdhc;
    logic [2:0]  err_code;
    logic [3:0]  dbg_state;

    sd_init_sequencer #(
        .DUMMY_CYCLES(DUMMY), .R1_TIMEOUT(R1_TO), .ACMD41_RETRIES(RETRIES), .GAP_BYTES(GAPB)
    ) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .sd_cmd(sd_cmd), .sd_start(sd_start),
        .sd_resp_toggle(sd_resp_toggle), .sd_resp(sd_resp),
        .busy(busy), .ready(ready), .error(error), .err_code(err_code), .sdhc(sdhc),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk = ~clk;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    logic [47:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          exp_ready;
    logic [2:0]  exp_code;
    bit          exp_sdhc;
    int          exp_pulses;
    logic [47:0] exp_last;

    bit          cfg_cmd0_timeout;
    logic [7:0]  cfg_cmd0_r1, cfg_cmd8_r1, cfg_cmd55_r1, cfg_cmd58_r1;
    logic [31:0] cfg_tail, cfg_ocr;
    int          cfg_acmd_ones;

    int n_acmd = 0;
    int dec_cycle = -10;
    int term_k = -1;
    int pulse_cnt = 0;
    int start_cycle = 0;
    bit first_pending = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_frame(logic [47:0] f);
        exp_q.push_back(f);
        exp_last = f;
    endfunction

    // Reference: walk the init rules over the card's configured answers.
    task automatic build_model();
        int n;
        int retries;
        bit r;
        exp_ready = 0;
        exp_sdhc  = 0;
        exp_code  = 3'd0;
        push_frame(F_CMD0);
        if (cfg_cmd0_timeout || cfg_cmd0_r1 != 8'h01) begin
            exp_code = 3'd1;
        end else begin
            push_frame(F_CMD8);
            if (cfg_cmd8_r1 != 8'h01 || cfg_tail[11:0] != 12'h1AA) begin
                exp_code = 3'd2;
            end else begin
                n = 0;
                retries = 0;
                while (exp_code == 3'd0) begin
                    push_frame(F_CMD55);
                    if (cfg_cmd55_r1 != 8'h00 && cfg_cmd55_r1 != 8'h01) begin
                        exp_code = 3'd5;
                    end else begin
                        push_frame(F_ACMD41);
                        r = (n < cfg_acmd_ones);
                        n++;
                        if (!r) break;
                        retries++;
                        if (retries >= RETRIES) exp_code = 3'd3;
                    end
                end
                if (exp_code == 3'd0) begin
                    push_frame(F_CMD58);
                    if (cfg_cmd58_r1 != 8'h00) begin
                        exp_code = 3'd4;
                    end else begin
                        exp_ready = 1;
                        exp_sdhc  = cfg_ocr[30];
                    end
                end
            end
        end
        exp_pulses = exp_q.size();
    endtask

    // ---------------- card / byte engine model ----------------
    initial begin
        logic [7:0] byte_q[$];
        int gap;
        int k;
        int dly;
        int rlen;
        logic [5:0] idx;
        logic [7:0] b;
        gap = 2;
        k = 0;
        forever begin
            @(negedge clk);
            if (sd_start) begin
                byte_q.delete();
                repeat (6) byte_q.push_back(8'hFF);
                dly = $urandom_range(0, 3);
                repeat (dly) byte_q.push_back(8'hFF);
                idx = sd_cmd[45:40];
                case (idx)
                    6'd0: if (!cfg_cmd0_timeout) byte_q.push_back(cfg_cmd0_r1);
                    6'd8: begin
                        byte_q.push_back(cfg_cmd8_r1);
                        for (int i = 3; i >= 0; i--) byte_q.push_back(cfg_tail[i*8 +: 8]);
                    end
                    6'd55: byte_q.push_back(cfg_cmd55_r1);
                    6'd41: begin
                        byte_q.push_back((n_acmd < cfg_acmd_ones) ? 8'h01 : 8'h00);
                        n_acmd++;
                    end
                    6'd58: begin
                        byte_q.push_back(cfg_cmd58_r1);
                        for (int i = 3; i >= 0; i--) byte_q.push_back(cfg_ocr[i*8 +: 8]);
                    end
                    default: ;
                endcase
                rlen = byte_q.size() - 6 - dly;
                term_k = (rlen > 0) ? (6 + dly + rlen) : (6 + R1_TO);
                k = 0;
                gap = $urandom_range(1, 3);
            end else if (gap == 0) begin
                b = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hFF;
                sd_resp = b;
                sd_resp_toggle = ~sd_resp_toggle;
                k++;
                if (k == term_k) dec_cycle = cyc;
                gap = $urandom_range(0, 3);
            end else begin
                gap--;
            end
        end
    end

    // ---------------- monitor ----------------
    bit m_prev_start = 0;
    bit m_prev_ready = 0;
    bit m_prev_error = 0;
    initial forever begin
        @(negedge clk);
        if (sd_start) begin
            pulse_cnt++;
            check("start_single_cycle", 64'(m_prev_start), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got frame %h, expected no launch", sd_cmd);
            end else begin
                check("cmd_frame", 64'(sd_cmd), 64'(exp_q.pop_front()));
            end
            if (first_pending) begin
                check("first_start_cycle", 64'(cyc), 64'(start_cycle + DUMMY + 1));
                first_pending = 0;
            end
        end
        if ((ready && !m_prev_ready) || (error && !m_prev_error))
            check("terminal_cycle", 64'(cyc), 64'(dec_cycle + 1));
        m_prev_start = sd_start;
        m_prev_ready = ready;
        m_prev_error = error;
    end

    // ---------------- driver ----------------
    task automatic set_nominal();
        cfg_cmd0_timeout = 0;
        cfg_cmd0_r1      = 8'h01;
        cfg_cmd8_r1      = 8'h01;
        cfg_tail         = 32'h000001AA;
        cfg_cmd55_r1     = 8'h01;
        cfg_acmd_ones    = 1;
        cfg_cmd58_r1     = 8'h00;
        cfg_ocr          = 32'hC0FF8000;
    endtask

    task automatic set_random();
        set_nominal();
        cfg_cmd0_timeout = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) cfg_cmd0_r1 = 8'h05;
        if ($urandom_range(0, 5) == 0) cfg_cmd8_r1 = 8'h05;
        if ($urandom_range(0, 4) == 0) cfg_tail = $urandom;
        case ($urandom_range(0, 5))
            0: cfg_cmd55_r1 = 8'h05;
            1: cfg_cmd55_r1 = 8'h00;
            default: cfg_cmd55_r1 = 8'h01;
        endcase
        cfg_acmd_ones = $urandom_range(0, 3);
        if ($urandom_range(0, 5) == 0) cfg_cmd58_r1 = 8'h09;
        cfg_ocr = $urandom;
    endtask

    task automatic launch();
        exp_q.delete();
        build_model();
        n_acmd = 0;
        @(negedge clk);
        init_start = 1'b1;
        start_cycle = cyc;
        first_pending = 1;
        @(negedge clk);
        init_start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("ready_cleared", 64'(ready), 64'd0);
        check("error_cleared", 64'(error), 64'd0);
        check("err_code_cleared", 64'(err_code), 64'd0);
    endtask

    task automatic run_scenario(string name);
        int n;
        int base;
        base = pulse_cnt;
        launch();
        n = 0;
        while (!(ready || error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, 64'(ready || error), 64'd1);
        repeat (10) @(negedge clk);
        check({name, "_ready"}, 64'(ready), 64'(exp_ready));
        check({name, "_error"}, 64'(error), 64'(!exp_ready));
        check({name, "_err_code"}, 64'(err_code), 64'(exp_code));
        check({name, "_sdhc"}, 64'(sdhc), 64'(exp_sdhc));
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_pulses"}, 64'(pulse_cnt - base), 64'(exp_pulses));
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({name, "_cmd_held"}, 64'(sd_cmd), 64'(exp_last));
    endtask

    initial begin
        int n;
        int snap;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sd_cmd", 64'(sd_cmd), 64'd0);
        check("rst_sd_start", 64'(sd_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_sdhc", 64'(sdhc), 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_no_start", 64'(pulse_cnt), 64'd0);

        set_nominal();
        run_scenario("nominal_sdhc");
        set_nominal();
        cfg_cmd0_timeout = 1;
        run_scenario("cmd0_timeout");
        set_nominal();
        cfg_tail = 32'h00000155;
        run_scenario("cmd8_echo");
        set_nominal();
        cfg_acmd_ones = 1000;
        run_scenario("acmd41_exhaust");
        set_nominal();
        cfg_ocr = 32'h80FF8000;
        run_scenario("sdsc");
        set_nominal();
        cfg_acmd_ones = 2;
        run_scenario("restart_from_ready");
        for (int i = 0; i < 8; i++) begin
            set_random();
            run_scenario($sformatf("random%0d", i));
        end

        // Reset in the middle of the CMD55/ACMD41 loop.
        set_nominal();
        cfg_acmd_ones = 2;
        launch();
        n = 0;
        while (n_acmd < 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_acmd41_loop", 64'(n_acmd >= 2), 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_sd_cmd", 64'(sd_cmd), 64'd0);
        check("midrst_sd_start", 64'(sd_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        check("midrst_err_code", 64'(err_code), 64'd0);
        check("midrst_sdhc", 64'(sdhc), 64'd0);
        exp_q.delete();
        first_pending = 0;
        snap = pulse_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("post_reset_no_start", 64'(pulse_cnt - snap), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

SPI-mode SD card power-up sequencer. It drives the byte-level SD SPI command engine through its `cmd`/`start` inputs and parses the R1/R7/R3 bytes that the engine returns through its `responseByte` toggle and `response` byte. It issues dummy clocks, then CMD0, CMD8, CMD55/ACMD41 (with retry), and CMD58. It reports ready, card capacity class, or an error code to the processor-side I/O logic.

## Interface
Parameters:
- `DUMMY_CYCLES`, 80: clk cycles held idle (no command launched) before CMD0; minimum 74.
- `R1_TIMEOUT`, 16: response bytes scanned for an R1 (MSB=0) before timeout.
- `ACMD41_RETRIES`, 1000: maximum CMD55+ACMD41 pairs before error.
- `GAP_BYTES`, 1: idle response bytes between the end of one command and the launch of the next.

Ports:
- `clk`, in, 1: SD-rate clock, same clock as the command engine.
- `reset`, in, 1: asynchronous, active-high.
- `init_start`, in, 1: a one-cycle pulse that begins the sequence. Ignored while `busy`.
- `sd_cmd`, out, 48: command frame presented to the engine.
- `sd_start`, out, 1: one-cycle launch pulse to the engine.
- `sd_resp_toggle`, in, 1: engine byte-done toggle.
- `sd_resp`, in, 8: engine byte, valid when the toggle changes.
- `busy`, out, 1: high from acceptance until ready or error.
- `ready`, out, 1: init succeeded; sticky until the next `init_start`.
- `error`, out, 1: init failed; sticky until the next `init_start`.
- `err_code`, out, 3: 1 = CMD0 bad/timeout, 2 = CMD8 bad/echo mismatch, 3 = ACMD41 retries exhausted, 4 = CMD58 bad/timeout, 5 = CMD55 bad, 0 = none.
- `sdhc`, out, 1: OCR CCS bit, valid when `ready`.

## Operation
- Byte event: `sd_resp_toggle != toggle_q`, where `toggle_q` is registered every cycle.
- Frames, each 47:0 = {0b01, index, arg[31:0], crc7, 1}:
  - CMD0 = 0x400000000095
  - CMD8 = 0x48000001AA87
  - CMD55 = 0x770000000001
  - ACMD41 = 0x694000000001
  - CMD58 = 0x7A0000000001
- States:
  - IDLE
  - DUMMY: count `DUMMY_CYCLES` clk.
  - ISSUE: pulse `sd_start` with `sd_cmd` stable.
  - SKIP: discard 6 command-period bytes.
  - WAIT_R1: take the first byte with MSB=0. If `R1_TIMEOUT` bytes arrive without one, the command errors.
  - TAIL: collect 4 bytes for CMD8/CMD58.
  - GAP: wait `GAP_BYTES` byte events.
  - CHECK
  - READY
  - ERROR
- Decisions in CHECK:
  - CMD0: R1 must be 0x01, else error 1.
  - CMD8: R1 must be 0x01, tail[11:0] must be 0x1AA, else error 2.
  - CMD55: R1 must be 0x00 or 0x01, else error 5.
  - ACMD41: R1 0x00 goes to CMD58. R1 0x01 increments the retry count and returns to CMD55. When the count reaches `ACMD41_RETRIES`, or on any other R1, error 3.
  - CMD58: R1 must be 0x00, else error 4. `sdhc` = first tail byte bit 6.
- `init_start` in READY or ERROR clears `ready`, `error`, `err_code`, `sdhc` and the retry count, then restarts at DUMMY.
- `sd_cmd` holds its last frame between commands. `sd_start` is never high two consecutive cycles.

## Timing
- Reset values: `sd_cmd` = 0x000000000000; `sd_start`, `busy`, `ready`, `error`, `sdhc` = 0; `err_code` = 0; state IDLE. Counters clear and `toggle_q` takes `sd_resp_toggle` at reset.
- `init_start` at cycle T: `busy` = 1 at T+1, and DUMMY runs T+1 … T+`DUMMY_CYCLES`. The CMD0 `sd_start` pulse occurs at T+`DUMMY_CYCLES`+1.
- `sd_cmd` is updated the cycle before `sd_start` and held until the next ISSUE.
- SKIP counts byte events after the pulse. The first event after the pulse is byte 1 of the command period.
- Terminal transitions: `ready`/`error` rise and `busy` falls in the same cycle, one cycle after the deciding byte event.
- Reset mid-sequence: all outputs return to reset values immediately. No further `sd_start` occurs until a new `init_start`.
- A byte event during DUMMY, IDLE, READY or ERROR is ignored.

## Test plan
- Nominal SDHC: card model returns 0x01 (CMD0); 0x01 + 00 00 01 AA (CMD8); 0x01 (CMD55); 0x01 then 0x00 (ACMD41); 0x00 + C0 FF 80 00 (CMD58) -> `ready`=1, `sdhc`=1, `err_code`=0, exactly 7 `sd_start` pulses.
- CMD0 timeout: card returns only 0xFF -> after 6 + 16 byte events, `error`=1, `err_code`=1, `busy`=0.
- CMD8 echo mismatch: tail 00 00 01 55 -> `error`=1, `err_code`=2.
- ACMD41 exhaustion with `ACMD41_RETRIES`=3: card always returns 0x01 -> 3 CMD55/ACMD41 pairs, then `err_code`=3.
- SDSC: OCR first byte 0x80 -> `ready`=1, `sdhc`=0. A following `init_start` clears `ready` within 1 cycle and the sequence repeats.
- Async reset asserted mid-ACMD41 loop -> all outputs 0 immediately, and no `sd_start` fires during 200 cycles after release.
